image_pixel_streamer: RTL and testbench

IMAGE_PIXEL_STREAMER -- requirements
Module: image_pixel_streamer

---
 rtl/image_pixel_streamer_pkg.sv | 17 +
 rtl/pix_skid_fifo.sv | 52 +++++
 rtl/image_pixel_streamer.sv | 126 ++++++++++++
 tb/tb_image_pixel_streamer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/image_pixel_streamer_pkg.sv
// Shared defaults and FSM encoding for the image pixel streamer.
package image_pixel_streamer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int IMG_W_DEF  = 4;

  // Tag bits carried alongside each pixel in the output FIFO.
  localparam int TAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pix_skid_fifo.sv
// Two-entry FIFO holding tagged pixels between the image RAM and the stream port.
module pix_skid_fifo #(
  parameter int W = 11
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_din,
  input  logic         i_pop,
  output logic [W-1:0] o_dout,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_do_pop;
  logic         w_do_push;

  assign w_do_pop  = i_pop & (r_count != 2'd0);
  assign w_do_push = i_push & ((r_count != 2'd2) | w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_din;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/image_pixel_streamer.sv
// Scans an image RAM in ascending address order and streams tagged pixels
// over a valid/ready port, using a 2-entry FIFO to absorb RAM read latency.
module image_pixel_streamer
  import image_pixel_streamer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IMG_W  = IMG_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              re,
  output logic [ADDR_W-1:0] rdaddress,
  input  logic [DATA_W-1:0] q,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              sof,
  output logic              eol,
  output logic              eof,
  output logic              busy,
  output logic              done
);

  localparam int FW = DATA_W + TAG_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_inflight;
  logic [TAG_W-1:0]    r_inflight_tag;
  logic                r_done;

  logic                w_re;
  logic                w_pop;
  logic [1:0]          w_count;
  logic [2:0]          w_credit;
  logic                w_last_addr;
  logic [TAG_W-1:0]    w_tag;
  logic [FW-1:0]       w_fifo_din;
  logic [FW-1:0]       w_fifo_dout;
  logic                w_fifo_valid;
  logic                w_head_sof;
  logic                w_head_eol;
  logic                w_head_eof;

  assign w_pop       = w_fifo_valid & pix_ready;
  assign w_last_addr = (r_addr == '1);

  // A pop in this cycle frees a slot, so it is credited before deciding to
  // issue a read; this keeps one pixel per cycle without ever overflowing.
  assign w_credit = {1'b0, w_count} - {2'b00, w_pop} + {2'b00, r_inflight};
  assign w_re     = (r_state == ST_READ) && (w_credit < 3'd2);

  assign w_tag = {(r_addr == '0),
                  ((int'(r_addr) % IMG_W) == (IMG_W - 1)),
                  w_last_addr};

  assign {w_head_sof, w_head_eol, w_head_eof} = w_fifo_dout[FW-1:DATA_W];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)                 w_state_next = ST_READ;
      ST_READ:  if (w_re && w_last_addr)   w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_pop && w_head_eof)   w_state_next = ST_IDLE;
      default:                             w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    re   = w_re;
    busy = (r_state != ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr         <= '0;
      r_inflight     <= 1'b0;
      r_inflight_tag <= '0;
      r_done         <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_addr <= '0;
      end else if (w_re && !w_last_addr) begin
        r_addr <= r_addr + 1'b1;
      end
      r_inflight     <= w_re;
      r_inflight_tag <= w_tag;
      r_done         <= (r_state == ST_DRAIN) && w_pop && w_head_eof;
    end
  end

  assign w_fifo_din = {r_inflight_tag, q};

  pix_skid_fifo #(
    .W (FW)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst_n (reset_n),
    .i_push  (r_inflight),
    .i_din   (w_fifo_din),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_valid (w_fifo_valid),
    .o_count (w_count)
  );

  assign rdaddress = r_addr;
  assign pix_valid = w_fifo_valid;
  assign pix_data  = w_fifo_dout[DATA_W-1:0];
  assign sof       = w_fifo_valid & w_head_sof;
  assign eol       = w_fifo_valid & w_head_eol;
  assign eof       = w_fifo_valid & w_head_eof;
  assign done      = r_done;

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Directed self-checking bench for image_pixel_streamer with a behavioural image RAM.
module tb_image_pixel_streamer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       start;
  logic       re;
  logic [3:0] rdaddress;
  logic [7:0] q;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       sof, eol, eof;
  logic       busy, done;

  int n_chk = 0;
  int n_err = 0;

  image_pixel_streamer #(
    .DATA_W (8),
    .ADDR_W (4),
    .IMG_W  (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .re        (re),
    .rdaddress (rdaddress),
    .q         (q),
    .pix_data  (pix_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .sof       (sof),
    .eol       (eol),
    .eof       (eof),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  // Image RAM preloaded with addr i -> 8'h10 + i, one cycle read latency.
  always @(posedge clock) begin
    if (re) q <= 8'h10 + {4'h0, rdaddress};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_re"},    re,        0);
    chk({tag, "_addr"},  rdaddress, 0);
    chk({tag, "_valid"}, pix_valid, 0);
    chk({tag, "_data"},  pix_data,  0);
    chk({tag, "_sof"},   sof,       0);
    chk({tag, "_eol"},   eol,       0);
    chk({tag, "_eof"},   eof,       0);
    chk({tag, "_busy"},  busy,      0);
    chk({tag, "_done"},  done,      0);
  endtask

  // mode 0: ready always high; 1: ready toggles; 2: ready low for 10 cycles.
  task automatic run_frame(input int mode, input bit restart);
    int idx = 0;
    int done_cnt = 0;
    int re_cnt = 0;
    int first_v = -1;
    int last_t = -1;
    int done_cyc = -1;
    logic [7:0] prev_data = '0;
    bit prev_stall = 0;
    start = 1'b1;
    pix_ready = 1'b0;
    @(negedge clock);
    for (int cyc = 1; cyc <= 120; cyc++) begin
      start = (restart && cyc == 5);
      case (mode)
        0:       pix_ready = 1'b1;
        1:       pix_ready = (cyc % 2 == 1);
        default: pix_ready = (cyc > 10);
      endcase
      if (cyc == 1) chk("busy_start", busy, 1);
      if (mode == 0 && cyc == 1) begin
        chk("first_re", re, 1);
        chk("first_addr", rdaddress, 0);
      end
      if (mode == 0 && cyc == 2) chk("second_addr", rdaddress, 1);
      if (mode == 2 && cyc <= 10) re_cnt += int'(re);
      if (mode == 2 && cyc == 10) begin
        chk("stall_re_le2", (re_cnt <= 2), 1);
        chk("stall_valid", pix_valid, 1);
        chk("stall_data", pix_data, 8'h10);
      end
      if (prev_stall) chk("hold_data", pix_data, prev_data);
      if (pix_valid && first_v < 0) first_v = cyc;
      if (pix_valid && pix_ready) begin
        chk("pix_data", pix_data, 8'h10 + idx);
        chk("sof", sof, (idx == 0));
        chk("eol", eol, (idx % 4 == 3));
        chk("eof", eof, (idx == 15));
        last_t = cyc;
        idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      if (done_cyc > 0 && cyc >= done_cyc + 3) break;
      @(negedge clock);
    end
    start = 1'b0;
    chk("pixel_count", idx, 16);
    chk("done_count", done_cnt, 1);
    chk("done_latency", done_cyc, last_t + 1);
    chk("first_valid_cyc", first_v, 3);
    chk("busy_end", busy, 0);
    if (mode == 0) chk("last_xfer_cyc", last_t, 18);
  endtask

  initial begin
    int idx;
    reset_n   = 1'b0;
    start     = 1'b0;
    pix_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clock);

    run_frame(0, 0);
    run_frame(1, 0);
    run_frame(2, 0);
    run_frame(0, 1);

    // Abort mid-frame after the 5th transfer.
    idx = 0;
    start = 1'b1;
    pix_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int cyc = 0; cyc < 40 && idx < 5; cyc++) begin
      if (pix_valid && pix_ready) idx++;
      if (idx < 5) @(negedge clock);
    end
    chk("abort_reached", idx, 5);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("abort");
    repeat (2) @(negedge clock);
    chk_idle_outputs("abort_hold");
    reset_n = 1'b1;
    @(negedge clock);
    run_frame(0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
